// File: rtl/pipe_pkg.sv
// Shared types and IF/ID payload layout for the pipeline stage registers.
package pipe_pkg;

  // Stage occupancy encoded as {skid_v, main_v}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned IFID_W         = 64;
  localparam int unsigned IFID_INSTR_LSB = 0;
  localparam int unsigned IFID_PC_LSB    = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  localparam logic [IFID_W-1:0] IFID_BUBBLE = {32'h0000_0000, NOP_INSTR};

  // Pack PC and instruction into the IF/ID payload bus
  function automatic logic [IFID_W-1:0] ifid_pack(input logic [31:0] pc,
                                                  input logic [31:0] instr);
    ifid_t p;
    p.pc    = pc;
    p.instr = instr;
    return p;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for stall-cycle statistics.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count up on inc, holding at the maximum value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush with bubble injection and a stall-cycle counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = IFID_W,
  parameter logic [DATA_W-1:0] RESET_VAL  = '0,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter bit                SKID_EN    = 1'b1,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  state_e            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              ready_q;
  logic              in_fire;
  logic              out_fire;

  // Handshake decode; ready is a register with the skid buffer, combinational without
  assign valid_o  = (state == ST_FULL) || (state == ST_SKID);
  assign data_o   = main_q;
  assign ready_o  = SKID_EN ? ready_q : (!valid_o || ready_i);
  assign in_fire  = valid_i && ready_o;
  assign out_fire = valid_o && ready_i;

  // Occupancy FSM: main register feeds downstream, skid catches the in-flight beat
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else if (flush_i) begin
      state   <= ST_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      ready_q <= 1'b1;
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state  <= ST_FULL;
            main_q <= data_i;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_q <= data_i;
          end else if (in_fire && SKID_EN) begin
            state   <= ST_SKID;
            skid_q  <= data_i;
            ready_q <= 1'b0;
          end else if (out_fire) begin
            state <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state  <= ST_FULL;
            main_q <= skid_q;
          end else begin
            ready_q <= 1'b0;
          end
        end
        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

  // Count cycles where downstream back-pressures a valid payload
  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk_i),
    .rst  (rst_i),
    .inc  (valid_o && !ready_i),
    .count(stall_cnt_o)
  );

  // Upstream may not retract or change a payload that is waiting for ready
  a_upstream_hold : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (valid_i && !ready_o && !flush_i) |=> (valid_i && $stable(data_i))
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: skid and non-skid instances, scoreboard on outputs.
module tb_pipe_stage_skid;

  localparam int unsigned  DW    = 64;
  localparam logic [DW-1:0] RST_V = 64'hDEAD_0000_0000_BEEF;
  localparam logic [DW-1:0] BUB_V = 64'h1234_0000_0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;           // 0: skid instance, 1: non-skid instance
  logic valid_i = 1'b0;
  logic ready_i = 1'b0;
  logic flush = 1'b0;
  logic [DW-1:0] data_i = '0;

  logic          va_o, ra_o, vb_o, rb_o;
  logic [DW-1:0] da_o, db_o;
  logic [15:0]   sa_o;
  logic [2:0]    sb_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W(DW), .RESET_VAL(RST_V), .BUBBLE_VAL(BUB_V), .SKID_EN(1'b1), .CNT_W(16)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i && !sel), .ready_o(ra_o),
    .data_i(data_i), .valid_o(va_o), .ready_i(ready_i), .data_o(da_o),
    .flush_i(flush), .stall_cnt_o(sa_o)
  );

  pipe_stage_skid #(
    .DATA_W(DW), .RESET_VAL(RST_V), .BUBBLE_VAL(BUB_V), .SKID_EN(1'b0), .CNT_W(3)
  ) u_dut_ns (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i && sel), .ready_o(rb_o),
    .data_i(data_i), .valid_o(vb_o), .ready_i(ready_i), .data_o(db_o),
    .flush_i(flush), .stall_cnt_o(sb_o)
  );

  // Selected instance view
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic [15:0]   m_stall;
  assign m_valid = sel ? vb_o : va_o;
  assign m_ready = sel ? rb_o : ra_o;
  assign m_data  = sel ? db_o : da_o;
  assign m_stall = sel ? 16'(sb_o) : sa_o;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accepted input, pop and compare on output handshake
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      chk("sb_valid", 64'(m_valid), 64'(sb_q.size() != 0));
      if (m_valid && ready_i && (sb_q.size() != 0)) begin
        chk("sb_data", m_data, sb_q.pop_front());
      end
      if (flush) begin
        sb_q.delete();
      end else if (valid_i && m_ready) begin
        sb_q.push_back(data_i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and release
    step(); step();
    chk("rst_valid", 64'(va_o), 64'(0));
    chk("rst_data", da_o, RST_V);
    chk("rst_ready", 64'(ra_o), 64'(0));
    chk("rst_stall", 64'(sa_o), 64'(0));
    rst = 1'b0;
    chk("rel_valid", 64'(va_o), 64'(0));
    chk("rel_data", da_o, RST_V);
    chk("rel_ready", 64'(ra_o), 64'(0));
    step();
    chk("rel_ready_1", 64'(ra_o), 64'(1));

    // Stream 1..8 with 1-cycle latency
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      valid_i = 1'b1;
      data_i  = 64'(i);
      step();
      chk("stream_valid", 64'(va_o), 64'(1));
      chk("stream_data", da_o, 64'(i));
      chk("stream_ready", 64'(ra_o), 64'(1));
    end
    valid_i = 1'b0;
    step();
    chk("stream_drain", 64'(va_o), 64'(0));
    chk("stream_stall", 64'(sa_o), 64'(0));

    // Back-pressure fills the skid buffer
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 64'hA;
    step();
    data_i = 64'hB;
    step();
    valid_i = 1'b0;
    chk("skid_ready", 64'(ra_o), 64'(0));
    chk("skid_data", da_o, 64'hA);
    for (int i = 0; i < 3; i++) step();
    chk("skid_hold_data", da_o, 64'hA);
    chk("skid_hold_ready", 64'(ra_o), 64'(0));
    chk("skid_stall", 64'(sa_o), 64'(4));
    ready_i = 1'b1;
    step();
    chk("skid_out_b", da_o, 64'hB);
    chk("skid_out_ready", 64'(ra_o), 64'(1));
    chk("skid_stall_hold", 64'(sa_o), 64'(4));
    step();
    chk("skid_drain", 64'(va_o), 64'(0));

    // Flush while in the skid state
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 64'hA;
    step();
    data_i = 64'hB;
    step();
    valid_i = 1'b0;
    flush   = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", 64'(va_o), 64'(0));
    chk("flush_data", da_o, BUB_V);
    chk("flush_ready", 64'(ra_o), 64'(1));
    chk("flush_stall", 64'(sa_o), 64'(6));
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_quiet", 64'(va_o), 64'(0));
    end

    // Flush drops the incoming beat but lets the outgoing one complete
    valid_i = 1'b1; data_i = 64'h77;
    step();
    chk("fl2_data", da_o, 64'h77);
    data_i = 64'h78; flush = 1'b1;
    step();
    flush = 1'b0; valid_i = 1'b0;
    chk("fl2_valid", 64'(va_o), 64'(0));
    chk("fl2_bubble", da_o, BUB_V);
    step();
    chk("fl2_dropped", 64'(va_o), 64'(0));

    // Asynchronous reset mid-stream
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 64'h55;
    step();
    valid_i = 1'b0;
    chk("mid_data", da_o, 64'h55);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(va_o), 64'(0));
    chk("mid_rst_data", da_o, RST_V);
    chk("mid_rst_stall", 64'(sa_o), 64'(0));
    chk("mid_rst_ready", 64'(ra_o), 64'(0));
    chk("ns_rst_ready", 64'(rb_o), 64'(1));
    chk("ns_rst_data", db_o, RST_V);
    step();
    rst = 1'b0;
    chk("mid_rel_ready", 64'(ra_o), 64'(0));
    step();
    chk("mid_rel_ready_1", 64'(ra_o), 64'(1));

    // Non-skid instance: stream
    sel = 1'b1;
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      valid_i = 1'b1;
      data_i  = 64'(i);
      step();
      chk("ns_stream_data", db_o, 64'(i));
      chk("ns_stream_ready", 64'(rb_o), 64'(1));
    end
    valid_i = 1'b0;
    step();
    chk("ns_drain", 64'(vb_o), 64'(0));

    // Non-skid instance: back-pressure with combinational ready
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 64'hA;
    step();
    data_i = 64'hB;
    chk("ns_bp_ready", 64'(rb_o), 64'(0));
    for (int i = 0; i < 3; i++) step();
    chk("ns_bp_data", db_o, 64'hA);
    chk("ns_bp_stall", 64'(sb_o), 64'(3));
    ready_i = 1'b1;
    #1;
    chk("ns_comb_ready", 64'(rb_o), 64'(1));
    step();
    valid_i = 1'b0;
    chk("ns_out_b", db_o, 64'hB);
    step();
    chk("ns_drain2", 64'(vb_o), 64'(0));

    // Stall counter saturation at 3 bits
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 64'hC;
    step();
    valid_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 3) chk("sat_pre", 64'(sb_o), 64'(6));
      if (k == 4) chk("sat_hit", 64'(sb_o), 64'(7));
    end
    chk("sat_hold", 64'(sb_o), 64'(7));
    chk("sat_data", db_o, 64'hC);
    ready_i = 1'b1;
    step();
    chk("sat_drain", 64'(vb_o), 64'(0));
    chk("sat_final", 64'(m_stall), 64'(7));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
